// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: dispatch allocation, execution writeback, operand lookup
// and in-order commit toward register_file, plus the mispredict flush.
//   slave  : the reorder buffer itself (receives alloc/wb/lookup/flush, drives commit)
//   master : the surrounding pipeline (dispatch, execution units, register_file)
interface reorder_buffer_if #(
  parameter int ID_W = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int N_LK = 2
);
  logic                 pred_miss;
  logic                 alloc_valid;
  logic                 alloc_has_dst;
  logic [AW-1:0]        alloc_dst;
  logic                 alloc_ready;
  logic [ID_W-1:0]      alloc_id;
  logic                 rsv;
  logic [ID_W-1:0]      rob_id;
  logic                 wb_valid;
  logic [ID_W-1:0]      wb_id;
  logic [DW-1:0]        wb_data;
  logic [N_LK*ID_W-1:0] lk_id;
  logic [N_LK*DW-1:0]   lk_data;
  logic [N_LK-1:0]      lk_done;
  logic                 we;
  logic [ID_W-1:0]      wrQueAddr;
  logic [AW-1:0]        wrAddr;
  logic [DW-1:0]        wrData;
  logic                 empty;
  logic [ID_W:0]        count;

  modport slave (
    input  pred_miss, alloc_valid, alloc_has_dst, alloc_dst, wb_valid, wb_id, wb_data, lk_id,
    output alloc_ready, alloc_id, rsv, rob_id, lk_data, lk_done, we, wrQueAddr, wrAddr, wrData,
           empty, count
  );

  modport master (
    output pred_miss, alloc_valid, alloc_has_dst, alloc_dst, wb_valid, wb_id, wb_data, lk_id,
    input  alloc_ready, alloc_id, rsv, rob_id, lk_data, lk_done, we, wrQueAddr, wrAddr, wrData,
           empty, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer.
// Allocates one entry per dispatched instruction (tail), collects out-of-order
// results by ROB id, serves operand lookups, and retires entries in program
// order (head), one per cycle, to register_file. pred_miss discards everything.
// Ports:
//   clk  : clock
//   nrst : synchronous, active-high reset
//   bus  : reorder_buffer_if.slave (alloc / rsv / wb / lookup / commit / status)
module reorder_buffer #(
  parameter int ID_W = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int N_LK = 2
) (
  input  logic             clk,
  input  logic             nrst,
  reorder_buffer_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ID_W;
  localparam logic [ID_W-1:0] PTR_ONE = 1;
  localparam logic [ID_W:0]   CNT_ONE = 1;
  localparam logic [ID_W:0]   CNT_DEPTH = DEPTH[ID_W:0];

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_has_dst;
  logic [AW-1:0]    r_dst  [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [ID_W-1:0]  r_head;
  logic [ID_W-1:0]  r_tail;
  logic [ID_W:0]    r_count;

  logic w_alloc_ready;
  logic w_fire;
  logic w_commit;
  logic w_wb_hit;
  logic [N_LK-1:0]    w_lk_done;
  logic [N_LK*DW-1:0] w_lk_data;

  // No same-cycle credit from a commit: readiness comes from the registered count only.
  assign w_alloc_ready = (r_count < CNT_DEPTH);
  assign w_fire        = bus.alloc_valid & w_alloc_ready & ~bus.pred_miss & ~nrst;
  // The commit is presented even in a flush cycle; register_file takes it unconditionally.
  assign w_commit      = r_valid[r_head] & r_done[r_head] & ~nrst;
  assign w_wb_hit      = bus.wb_valid & r_valid[bus.wb_id];

  assign bus.alloc_ready = w_alloc_ready;
  assign bus.alloc_id    = r_tail;
  assign bus.rob_id      = r_tail;
  assign bus.rsv         = w_fire & bus.alloc_has_dst;
  assign bus.we          = w_commit & r_has_dst[r_head];
  assign bus.wrQueAddr   = r_head;
  assign bus.wrAddr      = r_dst[r_head];
  assign bus.wrData      = r_data[r_head];
  assign bus.empty       = (r_count == '0);
  assign bus.count       = r_count;

  // Lookups read registered state only: a writeback becomes visible a cycle later.
  always_comb begin
    w_lk_done = '0;
    w_lk_data = '0;
    for (int i = 0; i < N_LK; i++) begin
      w_lk_done[i]          = r_valid[bus.lk_id[i*ID_W +: ID_W]] &
                              r_done[bus.lk_id[i*ID_W +: ID_W]];
      w_lk_data[i*DW +: DW] = r_data[bus.lk_id[i*ID_W +: ID_W]];
    end
  end

  assign bus.lk_done = w_lk_done;
  assign bus.lk_data = w_lk_data;

  // Control state. Reset and flush both return to the empty state.
  always_ff @(posedge clk) begin
    if (nrst || bus.pred_miss) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wb_hit) begin
        r_done[bus.wb_id] <= 1'b1;
      end
      // tail != head whenever both fire (count is neither 0 nor DEPTH), so no overlap.
      if (w_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + PTR_ONE;
      end
      // Last so a late writeback to the retiring entry cannot resurrect it.
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + PTR_ONE;
      end
      case ({w_fire, w_commit})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage, not reset.
  always_ff @(posedge clk) begin
    if (!nrst && !bus.pred_miss) begin
      if (w_wb_hit) begin
        r_data[bus.wb_id] <= bus.wb_data;
      end
      if (w_fire) begin
        r_has_dst[r_tail] <= bus.alloc_has_dst;
        r_dst[r_tail]     <= bus.alloc_dst;
      end
    end
  end
endmodule
